// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and width defaults for the cache port arbiter and its helpers.
package cache_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    // Requester identity used for grants and round-robin history.
    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Bundle of requester-side and cache-side signals around the arbiter.
// slave: the arbiter's view; master: the environment (requesters + cache).
interface cache_port_arbiter_if
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // Instruction fetch requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_valid;
    logic              i_stall;
    // Data load/store requester
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;
    // Cache port
    logic              c_rd;
    logic              c_wr;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic              c_stall;
    logic [DATA_W-1:0] c_dataout;

    modport slave (
        input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, c_stall, c_dataout,
        output i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
               c_rd, c_wr, c_addr, c_data
    );

    modport master (
        output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, c_stall, c_dataout,
        input  i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
               c_rd, c_wr, c_addr, c_data
    );

endinterface

// File: rtl/cache_port_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins outright; on conflict
// the requester that was not granted last time wins.
module rr_pick2
    import cache_arb_pkg::*;
(
    input  logic [1:0] req,         // bit 0: instruction, bit 1: data
    input  grant_t     last_grant,
    output grant_t     grant,
    output logic       grant_valid
);

    // Choose the winner from the pending set and the previous grant.
    always_comb begin
        grant       = INSTR;
        grant_valid = 1'b0;
        case (req)
            2'b01: begin
                grant       = INSTR;
                grant_valid = 1'b1;
            end
            2'b10: begin
                grant       = DATA;
                grant_valid = 1'b1;
            end
            2'b11: begin
                if (last_grant == INSTR) begin
                    grant = DATA;
                end else begin
                    grant = INSTR;
                end
                grant_valid = 1'b1;
            end
            default: begin
                grant       = INSTR;
                grant_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the single cache port between instruction fetch and data load/store.
// One request is latched at a time; the cache is driven only from holding
// registers so requester inputs may move freely while a transaction is open.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_port_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_SERVE_I = SERVE_I;
    localparam logic [1:0] S_SERVE_D = SERVE_D;
    localparam logic [1:0] S_DONE    = DONE;

    logic [1:0]        state_r;
    grant_t            last_grant_r;
    logic [ADDR_W-1:0] hold_addr_r;
    logic [DATA_W-1:0] hold_wdata_r;
    logic              hold_wr_r;
    logic              c_rd_r;
    logic              c_wr_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              i_valid_r;
    logic              d_valid_r;

    logic              d_req_s;
    logic [1:0]        req_s;
    grant_t            pick_grant_s;
    logic              pick_valid_s;

    assign d_req_s = bus.d_rd | bus.d_wr;
    assign req_s   = {d_req_s, bus.i_req};

    rr_pick2 u_pick (
        .req         (req_s),
        .last_grant  (last_grant_r),
        .grant       (pick_grant_s),
        .grant_valid (pick_valid_s)
    );

    // Transaction FSM with holding, strobe and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            last_grant_r <= INSTR;
            hold_addr_r  <= {ADDR_W{1'b0}};
            hold_wdata_r <= {DATA_W{1'b0}};
            hold_wr_r    <= 1'b0;
            c_rd_r       <= 1'b0;
            c_wr_r       <= 1'b0;
            i_rdata_r    <= {DATA_W{1'b0}};
            d_rdata_r    <= {DATA_W{1'b0}};
            i_valid_r    <= 1'b0;
            d_valid_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    i_valid_r <= 1'b0;
                    d_valid_r <= 1'b0;
                    if (pick_valid_s) begin
                        last_grant_r <= pick_grant_s;
                        if (pick_grant_s == DATA) begin
                            // A combined rd+wr request is served as a write.
                            hold_addr_r  <= bus.d_addr;
                            hold_wdata_r <= bus.d_wdata;
                            hold_wr_r    <= bus.d_wr;
                            c_wr_r       <= bus.d_wr;
                            c_rd_r       <= ~bus.d_wr;
                            state_r      <= S_SERVE_D;
                        end else begin
                            hold_addr_r  <= bus.i_addr;
                            hold_wdata_r <= {DATA_W{1'b0}};
                            hold_wr_r    <= 1'b0;
                            c_wr_r       <= 1'b0;
                            c_rd_r       <= 1'b1;
                            state_r      <= S_SERVE_I;
                        end
                    end
                end
                S_SERVE_I: begin
                    if (!bus.c_stall) begin
                        i_rdata_r <= bus.c_dataout;
                        c_rd_r    <= 1'b0;
                        c_wr_r    <= 1'b0;
                        i_valid_r <= 1'b1;
                        state_r   <= S_DONE;
                    end
                end
                S_SERVE_D: begin
                    if (!bus.c_stall) begin
                        if (!hold_wr_r) begin
                            d_rdata_r <= bus.c_dataout;
                        end
                        c_rd_r    <= 1'b0;
                        c_wr_r    <= 1'b0;
                        d_valid_r <= 1'b1;
                        state_r   <= S_DONE;
                    end
                end
                S_DONE: begin
                    i_valid_r <= 1'b0;
                    d_valid_r <= 1'b0;
                    state_r   <= S_IDLE;
                end
                default: begin
                    c_rd_r    <= 1'b0;
                    c_wr_r    <= 1'b0;
                    i_valid_r <= 1'b0;
                    d_valid_r <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.c_rd    = c_rd_r;
    assign bus.c_wr    = c_wr_r;
    assign bus.c_addr  = hold_addr_r;
    assign bus.c_data  = hold_wdata_r;
    assign bus.i_rdata = i_rdata_r;
    assign bus.d_rdata = d_rdata_r;
    assign bus.i_valid = i_valid_r;
    assign bus.d_valid = d_valid_r;
    assign bus.i_stall = bus.i_req & ~i_valid_r;
    assign bus.d_stall = d_req_s & ~d_valid_r;

endmodule
